// File: rtl/scr_descr_66b.sv
// rtl/scr_descr_66b.sv - 64b/66b self-synchronous scrambler/descrambler (x^58+x^39+1) with one-deep output register
// Tracks sync-header errors with a saturating counter.
module scr_descr_66b #(
  parameter int DW   = 64,
  parameter int SW   = 6,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode_i,
  input  logic            bypass_i,
  input  logic            seed_load_i,
  input  logic [57:0]     seed_i,
  input  logic            vld_i,
  output logic            rdy_o,
  input  logic [DW-1:0]   data_i,
  input  logic [1:0]      head_i,
  input  logic [SW-1:0]   seq_i,
  output logic            vld_o,
  input  logic            rdy_i,
  output logic [DW-1:0]   data_o,
  output logic [1:0]      head_o,
  output logic [SW-1:0]   seq_o,
  output logic            hdr_err_o,
  output logic [CNTW-1:0] err_cnt_o,
  input  logic            err_clr_i
);

  logic [57:0]   s;
  logic [57:0]   s_next;
  logic [DW-1:0] proc;
  logic          xfer;
  logic          hdr_bad;

  // Unrolled serial recurrence: bit 0 first, each bit sees the state left by the previous one.
  always_comb begin
    s_next = s;
    proc   = '0;
    for (int i = 0; i < DW; i++) begin
      proc[i] = s_next[0] ^ s_next[19] ^ data_i[i];
      s_next  = {(mode_i ? data_i[i] : proc[i]), s_next[57:1]};
    end
  end

  assign rdy_o   = !vld_o || rdy_i;
  assign xfer    = vld_i && rdy_o;
  assign hdr_bad = (head_i[0] ~^ head_i[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '1;
    end else if (seed_load_i) begin
      s <= seed_i;
    end else if (xfer && !bypass_i) begin
      s <= s_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o     <= 1'b0;
      data_o    <= '0;
      head_o    <= 2'b00;
      seq_o     <= '0;
      hdr_err_o <= 1'b0;
    end else if (xfer) begin
      vld_o     <= 1'b1;
      data_o    <= bypass_i ? data_i : proc;
      head_o    <= head_i;
      seq_o     <= seq_i;
      hdr_err_o <= hdr_bad;
    end else if (rdy_i) begin
      vld_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_o <= '0;
    end else if (err_clr_i) begin
      err_cnt_o <= '0;
    end else if (xfer && hdr_bad && !(&err_cnt_o)) begin
      err_cnt_o <= err_cnt_o + CNTW'(1);
    end
  end

endmodule

// File: doc/scr_descr_66b.md
SCR_DESCR_66B -- requirements
Module: scr_descr_66b

Interface
REQ-001 Parameter DW, default 64: data bits per block; legal values 32 and 64.
REQ-002 Parameter SW, default 6: width of the sequence tag passed alongside the data.
REQ-003 Parameter CNTW, default 16: width of the header-error counter.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 mode_i  in  1  0 = scramble, 1 = descramble; sampled with each accepted block.
REQ-007 bypass_i  in  1  1 = data passes unscrambled and the LFSR holds; sampled with each accepted block.
REQ-008 seed_load_i  in  1  1-cycle pulse that loads the LFSR from seed_i.
REQ-009 seed_i  in  58  LFSR seed value.
REQ-010 vld_i  in  1  input block valid.
REQ-011 rdy_o  out  1  input block ready.
REQ-012 data_i  in  DW  payload, bit 0 transmitted first.
REQ-013 head_i  in  2  sync header.
REQ-014 seq_i  in  SW  sequence tag.
REQ-015 vld_o  out  1  output block valid.
REQ-016 rdy_i  in  1  downstream ready.
REQ-017 data_o  out  DW; head_o  out  2; seq_o  out  SW: output block.
REQ-018 hdr_err_o  out  1  header of the current output block is 2'b00 or 2'b11.
REQ-019 err_cnt_o  out  CNTW  saturating count of header errors.
REQ-020 err_clr_i  in  1  synchronous clear of err_cnt_o.

Function
REQ-021 Polynomial x^58+x^39+1; 58-bit state s; bits processed LSB first, serially equivalent within one cycle.
REQ-022 Scramble, per bit d: t = s[0]^s[19]^d; output bit = t; s <= {t, s[57:1]}.
REQ-023 Descramble, per bit d: output bit = s[0]^s[19]^d; s <= {d, s[57:1]}.
REQ-024 Transfer occurs when vld_i && rdy_o; rdy_o = !vld_o || rdy_i (single output register, combinational ready, latency 1 cycle).
REQ-025 On transfer: data_o/head_o/seq_o load the processed block and vld_o <= 1; head and seq pass through unmodified.
REQ-026 Output is consumed when vld_o && rdy_i; if there is no new transfer in that cycle, vld_o <= 0.
REQ-027 While vld_o && !rdy_i: data_o, head_o, seq_o, vld_o and s all hold.
REQ-028 s advances only on a transfer with bypass_i = 0; with bypass_i = 1, data_o = data_i and s is unchanged.
REQ-029 seed_load_i takes priority over any transfer in the same cycle: s <= seed_i; the block transfers using the pre-load state; the seed takes effect from the next block.
REQ-030 hdr_err_o is registered with the block, valid only while vld_o = 1, and evaluated in both modes and in bypass.
REQ-031 err_cnt_o increments by 1 on each transfer with an erroneous header and saturates at all ones.
REQ-032 err_clr_i takes priority over an increment in the same cycle.
REQ-033 A change of mode_i or bypass_i while no transfer occurs has no effect.

Reset
REQ-034 While rst_n = 0: s = all ones; vld_o = 0; data_o = 0; head_o = 2'b00; seq_o = 0; hdr_err_o = 0; err_cnt_o = 0.
REQ-035 Assertion mid-transfer discards the block in flight; first valid output is one cycle after the first transfer following release.

Verification
REQ-036 After reset, scramble, DW = 64, data_i = 0, head = 2'b01, rdy_i = 1 -> next cycle vld_o = 1, data_o[38:0] = 0, data_o[57:39] = all ones, head_o = 2'b01.
REQ-037 Loopback of 1000 random blocks through a scrambler instance into a descrambler instance (both reset) -> descrambled data equals source data; head and seq are identical and in order.
REQ-038 Hold rdy_i = 0 for 5 cycles with vld_i = 1 -> rdy_o = 0, outputs are stable, no block is lost or duplicated, and s matches the reference model on resume.
REQ-039 seed_load_i pulse with seed_i = 58'h3 while a transfer occurs -> that block uses the old state, the next block matches the model seeded with 58'h3.
REQ-040 Headers 00, 11, 01, 10, 00 -> hdr_err_o = 1,1,0,0,1; err_cnt_o = 3; with CNTW = 2, five error blocks -> err_cnt_o = 3; err_clr_i together with an error block -> err_cnt_o = 0.
REQ-041 Bypass block inserted between scrambled blocks -> data_o = data_i for the bypass block, and the following scrambled blocks are unchanged versus the model with the bypass block removed.
